reg_file_dumper: RTL and testbench

- Read-side sequencer for the 8x8-bit reg_file.
- Drives the two read-address ports (out1address/out2address) and sweeps all registers two at a time: even register on port 1, odd register on port 2.
- Captures the read data and streams it out one byte per valid/ready transfer, in register order 0..7.
- Optional zero-check mode flags any nonzero register. Used after reset to prove the register clear, and for end-of-test dumps.

---
 rtl/reg_file_dumper_if.sv | 24 ++
 rtl/reg_file_dumper.sv | 161 ++++++++++++++++
 tb/tb_reg_file_dumper.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_dumper_if.sv
// rtl/reg_file_dumper_if.sv - byte dump stream between the reg_file dumper and its sink
interface reg_file_dumper_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_valid;
    logic              dump_ready;

    modport master (
        output dump_data,
        output dump_addr,
        output dump_valid,
        input  dump_ready
    );

    modport slave (
        input  dump_data,
        input  dump_addr,
        input  dump_valid,
        output dump_ready
    );
endinterface

// File: rtl/reg_file_dumper.sv
// rtl/reg_file_dumper.sv - sweeps the reg_file two registers at a time and streams them out
// with an optional all-zero check.
module reg_file_dumper #(
    parameter int NUM_REGS      = 8,
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  zero_check,
    output logic [ADDR_W-1:0]     out1address,
    output logic [ADDR_W-1:0]     out2address,
    input  logic [DATA_W-1:0]     out1,
    input  logic [DATA_W-1:0]     out2,
    reg_file_dumper_if.master     dump,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W-1:0]     err_addr
);
    localparam int PAIR_W = ADDR_W - 1;
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PAIR_W-1:0] LAST_P = PAIR_W'(NUM_REGS / 2 - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CAPTURE,
        EMIT_A,
        EMIT_B,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PAIR_W-1:0] pair;
    logic [PAIR_W-1:0] pair_inc;
    logic [CNT_W-1:0]  settle_cnt;
    logic [DATA_W-1:0] buf_a;
    logic [DATA_W-1:0] buf_b;
    logic              zc_mode;
    logic              last_pair;
    logic              a_bad;
    logic              pair_bad;

    logic [DATA_W-1:0] dump_data_c;
    logic [ADDR_W-1:0] dump_addr_c;
    logic              dump_valid_c;

    assign pair_inc  = pair + 1'b1;
    assign last_pair = (pair == LAST_P);
    assign a_bad     = (out1 != '0);
    assign pair_bad  = a_bad || (out2 != '0);

    always_comb begin
        state_next   = state;
        dump_valid_c = 1'b0;
        dump_data_c  = '0;
        dump_addr_c  = '0;
        busy         = (state != IDLE);
        done         = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = EMIT_A;
            end
            EMIT_A: begin
                dump_valid_c = 1'b1;
                dump_data_c  = buf_a;
                dump_addr_c  = {pair, 1'b0};
                if (dump.dump_ready) begin
                    state_next = EMIT_B;
                end
            end
            EMIT_B: begin
                dump_valid_c = 1'b1;
                dump_data_c  = buf_b;
                dump_addr_c  = {pair, 1'b1};
                if (dump.dump_ready) begin
                    state_next = last_pair ? DONE : SETUP;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dump.dump_valid = dump_valid_c;
    assign dump.dump_data  = dump_data_c;
    assign dump.dump_addr  = dump_addr_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pair        <= '0;
            settle_cnt  <= '0;
            out1address <= '0;
            out2address <= '0;
            buf_a       <= '0;
            buf_b       <= '0;
            zc_mode     <= 1'b0;
            error       <= 1'b0;
            err_addr    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        pair        <= '0;
                        settle_cnt  <= '0;
                        zc_mode     <= zero_check;
                        error       <= 1'b0;
                        err_addr    <= '0;
                        out1address <= '0;
                        out2address <= ADDR_W'(1);
                    end
                end
                SETUP: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                CAPTURE: begin
                    buf_a <= out1;
                    buf_b <= out2;
                    // Only the first failing register is reported; later ones just keep error set.
                    if (zc_mode && pair_bad) begin
                        error <= 1'b1;
                        if (!error) begin
                            err_addr <= a_bad ? {pair, 1'b0} : {pair, 1'b1};
                        end
                    end
                end
                EMIT_B: begin
                    if (dump.dump_ready && !last_pair) begin
                        pair        <= pair_inc;
                        settle_cnt  <= '0;
                        out1address <= {pair_inc, 1'b0};
                        out2address <= {pair_inc, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_dumper.sv
// tb/tb_reg_file_dumper.sv - directed self-checking bench for reg_file_dumper
// against a registered-read reg_file model.
module tb_reg_file_dumper;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       start3;
    logic       zero_check;
    logic [2:0] a1, a2, a1_3, a2_3;
    logic [7:0] rd1, rd2, rd1_3, rd2_3;
    logic       busy, done, error, busy3, done3, error3;
    logic [2:0] err_addr, err_addr3;

    logic [7:0] regs [8];
    logic [7:0] exp_d [8];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n0;
    int base;

    logic [7:0] q_data [$];
    logic [2:0] q_addr [$];
    int         q_cyc  [$];
    int         q_done [$];
    logic [7:0] q3_data [$];
    logic [2:0] q3_addr [$];
    int         q3_cyc  [$];
    int         q3_done [$];

    logic       stall_prev = 1'b0;
    logic [7:0] prev_d;
    logic [2:0] prev_a;

    reg_file_dumper_if #(.ADDR_W(3), .DATA_W(8)) dif ();
    reg_file_dumper_if #(.ADDR_W(3), .DATA_W(8)) dif3 ();

    assign dif3.dump_ready = 1'b1;

    reg_file_dumper #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .start(start), .zero_check(zero_check),
        .out1address(a1), .out2address(a2), .out1(rd1), .out2(rd2),
        .dump(dif.master), .busy(busy), .done(done), .error(error), .err_addr(err_addr)
    );

    reg_file_dumper #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .zero_check(zero_check),
        .out1address(a1_3), .out2address(a2_3), .out1(rd1_3), .out2(rd2_3),
        .dump(dif3.master), .busy(busy3), .done(done3), .error(error3), .err_addr(err_addr3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rd1   <= regs[a1];
        rd2   <= regs[a2];
        rd1_3 <= regs[a1_3];
        rd2_3 <= regs[a2_3];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (stall_prev) begin
                check("stall_valid", dif.dump_valid, 1);
                check("stall_data", dif.dump_data, prev_d);
                check("stall_addr", dif.dump_addr, prev_a);
            end
            if (dif.dump_valid && dif.dump_ready) begin
                q_data.push_back(dif.dump_data);
                q_addr.push_back(dif.dump_addr);
                q_cyc.push_back(cyc);
            end
            stall_prev = dif.dump_valid && !dif.dump_ready;
            prev_d = dif.dump_data;
            prev_a = dif.dump_addr;
            if (done) q_done.push_back(cyc);
            if (dif3.dump_valid && dif3.dump_ready) begin
                q3_data.push_back(dif3.dump_data);
                q3_addr.push_back(dif3.dump_addr);
                q3_cyc.push_back(cyc);
            end
            if (done3) q3_done.push_back(cyc);
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check_dump(input string tag);
        check({tag, "_count"}, q_data.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < q_data.size()) begin
                check({tag, "_addr"}, q_addr[base + i], i);
                check({tag, "_data"}, q_data[base + i], exp_d[i]);
            end
        end
    endtask

    // mode 1: sink stalls 3 cycles when addr3 first appears, then alternates
    task automatic run_sweep(input logic zc, input int mode, input int pulse_at);
        int  db;
        int  hold;
        bit  armed;
        bit  alt;
        bit  fin;
        db = q_done.size();
        base = q_data.size();
        hold = 0;
        armed = 0;
        alt = 1;
        fin = 0;
        dif.dump_ready = 1'b1;
        zero_check = zc;
        start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        start = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            if (mode == 1) begin
                if (!armed && dif.dump_valid && dif.dump_addr == 3'd3) begin
                    armed = 1;
                    hold = 3;
                end
                if (hold > 0) begin
                    dif.dump_ready = 1'b0;
                    hold--;
                end else if (armed) begin
                    dif.dump_ready = alt;
                    alt = !alt;
                end else begin
                    dif.dump_ready = 1'b1;
                end
            end
            start = (pulse_at > 0 && (k == pulse_at || k == pulse_at + 1)) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            if (q_done.size() > db) fin = 1;
        end
        start = 1'b0;
        dif.dump_ready = 1'b1;
        check("sweep_finished", fin, 1);
    endtask

    initial begin
        bit found;
        int db;
        reset = 1'b1;
        start = 1'b0;
        start3 = 1'b0;
        zero_check = 1'b0;
        dif.dump_ready = 1'b1;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out1address", a1, 0);
        check("rst_out2address", a2, 0);
        check("rst_dump_data", dif.dump_data, 0);
        check("rst_dump_addr", dif.dump_addr, 0);
        check("rst_dump_valid", dif.dump_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_addr", err_addr, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Scenario 1: preload pattern, ready always high
        regs[0] = 8'hFF; regs[1] = 8'h01; regs[2] = 8'h03; regs[3] = 8'h07;
        regs[4] = 8'h0F; regs[5] = 8'h1F; regs[6] = 8'h3F; regs[7] = 8'h7F;
        exp_d[0] = 8'hFF; exp_d[1] = 8'h01; exp_d[2] = 8'h03; exp_d[3] = 8'h07;
        exp_d[4] = 8'h0F; exp_d[5] = 8'h1F; exp_d[6] = 8'h3F; exp_d[7] = 8'h7F;
        db = q_done.size();
        run_sweep(1'b0, 0, 0);
        check_dump("s1");
        if (q_cyc.size() > base) check("s1_first_valid_lat", q_cyc[base] - n0, 2);
        if (q_done.size() > db) check("s1_done_lat", q_done[db] - n0, 16);
        check("s1_busy_after", busy, 0);
        check("s1_error", error, 0);

        // SETTLE_CYCLES=3 instance on the same preload
        start3 = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        start3 = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (q3_done.size() > 0) found = 1;
        end
        check("s3c_finished", found, 1);
        check("s3c_count", q3_data.size(), 8);
        if (q3_cyc.size() > 0) check("s3c_first_valid_lat", q3_cyc[0] - n0, 4);
        if (q3_done.size() > 0) check("s3c_done_lat", q3_done[0] - n0, 24);
        for (int i = 0; i < 8; i++) begin
            if (i < q3_data.size()) begin
                check("s3c_addr", q3_addr[i], i);
                check("s3c_data", q3_data[i], exp_d[i]);
            end
        end

        // Scenario 2: reg_file cleared, zero-check passes
        for (int i = 0; i < 8; i++) begin
            regs[i] = 8'h00;
            exp_d[i] = 8'h00;
        end
        run_sweep(1'b1, 0, 0);
        check_dump("s2");
        check("s2_error", error, 0);

        // Scenario 3: reg2 and reg5 nonzero, first failure is reported
        regs[2] = 8'h03; regs[5] = 8'h80;
        exp_d[2] = 8'h03; exp_d[5] = 8'h80;
        run_sweep(1'b1, 0, 0);
        check_dump("s3");
        check("s3_error", error, 1);
        check("s3_err_addr", err_addr, 2);
        repeat (3) @(posedge clk);
        #1;
        check("s3_error_sticky", error, 1);

        // Scenario 4: stalls starting at addr3, error cleared by new start
        regs[0] = 8'hFF; regs[1] = 8'h01; regs[2] = 8'h03; regs[3] = 8'h07;
        regs[4] = 8'h0F; regs[5] = 8'h1F; regs[6] = 8'h3F; regs[7] = 8'h7F;
        exp_d[0] = 8'hFF; exp_d[1] = 8'h01; exp_d[2] = 8'h03; exp_d[3] = 8'h07;
        exp_d[4] = 8'h0F; exp_d[5] = 8'h1F; exp_d[6] = 8'h3F; exp_d[7] = 8'h7F;
        run_sweep(1'b0, 1, 0);
        check_dump("s4");
        check("s4_error_cleared", error, 0);

        // Scenario 5: reset during EMIT_B of pair 1
        db = q_done.size();
        base = q_data.size();
        dif.dump_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (dif.dump_valid && dif.dump_addr == 3'd3) found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("s5_reached_addr3", found, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("s5_valid_dropped", dif.dump_valid, 0);
        check("s5_busy", busy, 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("s5_no_done", q_done.size() - db, 0);
        check("s5_partial_count", q_data.size() - base, 3);
        run_sweep(1'b0, 0, 0);
        check_dump("s5_restart");

        // Scenario 6: start pulsed while busy is ignored
        db = q_done.size();
        run_sweep(1'b0, 0, 5);
        repeat (4) @(posedge clk);
        #1;
        check_dump("s6");
        check("s6_one_done", q_done.size() - db, 1);
        check("s6_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
